// File: rtl/qspi_rom_fetch_ctrl_if.sv
// ROM fetch bundle: console request/response handshake plus the QSPI PMOD pins.
// The master side is the console and flash; the slave side is the fetch controller.
interface qspi_rom_fetch_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic              qspi_cs_n;
    logic              qspi_sclk;
    logic [3:0]        qspi_io_out;
    logic              qspi_io_oe;
    logic [3:0]        qspi_io_in;

    modport master (
        output req_valid, req_addr, qspi_io_in,
        input  req_ready, rsp_valid, rsp_data,
        input  qspi_cs_n, qspi_sclk, qspi_io_out, qspi_io_oe
    );

    modport slave (
        input  req_valid, req_addr, qspi_io_in,
        output req_ready, rsp_valid, rsp_data,
        output qspi_cs_n, qspi_sclk, qspi_io_out, qspi_io_oe
    );
endinterface

// File: rtl/qspi_rom_fetch_ctrl.sv
// Single-byte quad-SPI ROM fetch: command, address, dummy and data nibbles
// on a clk/2 serial clock, with a one-entry last-address buffer that answers
// repeated fetches without touching the bus.
module qspi_rom_fetch_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [7:0]  CMD       = 8'hEB,
    parameter int          DUMMY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qspi_rom_fetch_ctrl_if.slave bus
);
    // Slot indices (one slot = 2 clk cycles) where each phase ends.
    localparam logic [4:0] SLOT_CMD_END  = 5'd1;
    localparam logic [4:0] SLOT_ADDR_END = 5'd7;
    localparam logic [4:0] SLOT_DMY_END  = 5'(7 + DUMMY);
    localparam logic [4:0] SLOT_LAST     = 5'(9 + DUMMY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_ph;
    logic [4:0]        r_slot;
    logic [23:0]       r_sh;
    logic [3:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [7:0]        r_buf_data;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_data;
    logic              r_cs_n;
    logic              r_sclk;
    logic [3:0]        r_io_out;
    logic              r_io_oe;

    logic              w_hit;
    logic [7:0]        w_byte;

    assign w_hit  = r_buf_valid && (bus.req_addr == r_buf_addr);
    assign w_byte = {r_hi, bus.qspi_io_in};

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.qspi_cs_n   = r_cs_n;
    assign bus.qspi_sclk   = r_sclk;
    assign bus.qspi_io_out = r_io_out;
    assign bus.qspi_io_oe  = r_io_oe;

    // Fetch sequencer; every pin and handshake output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ph        <= 1'b0;
            r_slot      <= 5'd0;
            r_sh        <= 24'd0;
            r_hi        <= 4'd0;
            r_addr      <= '0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= 8'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b0;
            r_io_out    <= 4'd0;
            r_io_oe     <= 1'b0;
        end else begin
            // Serial clock follows the phase bit while the bus is active.
            if (r_state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) begin
                r_ph   <= ~r_ph;
                r_sclk <= ~r_ph;
            end
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (r_req_ready && bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        if (w_hit) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_buf_data;
                        end else begin
                            r_state  <= ST_CMD;
                            r_addr   <= bus.req_addr;
                            r_sh     <= BASE_ADDR + 24'(bus.req_addr);
                            r_ph     <= 1'b0;
                            r_sclk   <= 1'b0;
                            r_slot   <= 5'd0;
                            r_cs_n   <= 1'b0;
                            r_io_oe  <= 1'b1;
                            r_io_out <= CMD[7:4];
                        end
                    end
                end
                ST_CMD: begin
                    if (r_ph) begin
                        r_slot <= r_slot + 5'd1;
                        if (r_slot == SLOT_CMD_END) begin
                            r_state  <= ST_ADDR;
                            r_io_out <= r_sh[23:20];
                            r_sh     <= r_sh << 4;
                        end else begin
                            r_io_out <= CMD[3:0];
                        end
                    end
                end
                ST_ADDR: begin
                    if (r_ph) begin
                        r_slot <= r_slot + 5'd1;
                        if (r_slot == SLOT_ADDR_END) begin
                            r_state  <= (DUMMY == 0) ? ST_DATA : ST_DUMMY;
                            r_io_oe  <= 1'b0;
                            r_io_out <= 4'd0;
                        end else begin
                            r_io_out <= r_sh[23:20];
                            r_sh     <= r_sh << 4;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (r_ph) begin
                        r_slot <= r_slot + 5'd1;
                        if (r_slot == SLOT_DMY_END)
                            r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Flash data is taken at the falling sclk edge, i.e. the end of each ph=1 cycle.
                    if (r_ph) begin
                        r_hi <= bus.qspi_io_in;
                        if (r_slot == SLOT_LAST) begin
                            r_state     <= ST_DONE;
                            r_cs_n      <= 1'b1;
                            r_sclk      <= 1'b0;
                            r_ph        <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_byte;
                            r_buf_valid <= 1'b1;
                            r_buf_addr  <= r_addr;
                            r_buf_data  <= w_byte;
                        end else begin
                            r_slot <= r_slot + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_io_oe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_rom_fetch_ctrl.sv
// Bench for qspi_rom_fetch_ctrl: three instances (default, wrapping base
// offset, zero dummy slots) driven by tasks and checked cycle by cycle
// against a slot-schedule reference model and a last-address buffer model.
module tb_qspi_rom_fetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;

    logic        rv[3];
    logic [11:0] ra[3];
    logic [3:0]  ii[3];
    logic        rr[3], vv[3], cs[3], sk[3], oe[3];
    logic [7:0]  rd[3];
    logic [3:0]  io[3];

    // Reference buffer state per instance.
    bit          mb_v[3];
    logic [11:0] mb_a[3];
    logic [7:0]  mb_d[3];

    qspi_rom_fetch_ctrl_if #(.ADDR_W(12)) bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req_valid  = rv[g];
        assign bus[g].req_addr   = ra[g];
        assign bus[g].qspi_io_in = ii[g];
        assign rr[g] = bus[g].req_ready;
        assign vv[g] = bus[g].rsp_valid;
        assign rd[g] = bus[g].rsp_data;
        assign cs[g] = bus[g].qspi_cs_n;
        assign sk[g] = bus[g].qspi_sclk;
        assign io[g] = bus[g].qspi_io_out;
        assign oe[g] = bus[g].qspi_io_oe;
        qspi_rom_fetch_ctrl #(
            .ADDR_W   (12),
            .BASE_ADDR((g == 1) ? 24'hFFFFF0 : 24'h000000),
            .CMD      (8'hEB),
            .DUMMY    ((g == 2) ? 0 : 4)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus[g])
        );
    end

    function automatic int dmy(input int s);
        return (s == 2) ? 0 : 4;
    endfunction

    function automatic logic [23:0] base(input int s);
        return (s == 1) ? 24'hFFFFF0 : 24'h000000;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) mb_v[s] = 0;
    endtask

    // One fetch on instance s; positioned at a negedge on entry and exit.
    task automatic run_txn(input int s, input logic [11:0] addr, input logic [7:0] fbyte,
                           input bit hold, input logic [11:0] next_addr);
        int n, last, k, w;
        bit hit, chk_io;
        logic [7:0]  exp_d;
        logic [23:0] a;
        logic [7:0]  cmd_b;
        logic [4:0]  exp_ctl, got_ctl;
        logic [3:0]  exp_io;
        hit   = mb_v[s] && (mb_a[s] == addr);
        exp_d = hit ? mb_d[s] : fbyte;
        n     = 10 + dmy(s);
        last  = hit ? 1 : 2 * n + 1;
        a     = base(s) + {12'h000, addr};
        cmd_b = 8'hEB;
        w = 0;
        while (rr[s] !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (rr[s] !== 1'b1) begin
            fails++;
            $display("FAIL ready_wait s%0d: req_ready=%b required 1", s, rr[s]);
        end
        rv[s] = 1'b1;
        ra[s] = addr;
        @(negedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            if (c == 1) begin
                if (hold) ra[s] = next_addr;
                else rv[s] = 1'b0;
            end
            chk_io = 0;
            exp_io = 4'd0;
            // exp_ctl = {cs_n, sclk, io_oe, rsp_valid, req_ready}
            if (c == last)          exp_ctl = 5'b10010;
            else if (c == last + 1) exp_ctl = 5'b10001;
            else begin
                k = (c - 1) / 2;
                exp_ctl = {1'b0, (c % 2 == 0), (k < 8), 2'b00};
                if (k < 2) begin
                    chk_io = 1;
                    exp_io = (k == 0) ? cmd_b[7:4] : cmd_b[3:0];
                end else if (k < 8) begin
                    chk_io = 1;
                    exp_io = 4'((a >> (4 * (7 - k))) & 24'hF);
                end else if (k < 8 + dmy(s)) begin
                    chk_io = 1;
                end
            end
            got_ctl = {cs[s], sk[s], oe[s], vv[s], rr[s]};
            tests++;
            if (got_ctl !== exp_ctl) begin
                fails++;
                $display("FAIL ctl s%0d cyc%0d: {cs_n,sclk,oe,rsp_valid,ready}=%b required %b",
                         s, c, got_ctl, exp_ctl);
            end
            if (chk_io) begin
                tests++;
                if (io[s] !== exp_io) begin
                    fails++;
                    $display("FAIL io_out s%0d cyc%0d: got %h required %h", s, c, io[s], exp_io);
                end
            end
            if (c >= last) begin
                tests++;
                if (rd[s] !== exp_d) begin
                    fails++;
                    $display("FAIL rsp_data s%0d cyc%0d: got %h required %h", s, c, rd[s], exp_d);
                end
            end
            // Flash model: present the data nibble for the sclk-high cycle of each data slot.
            if (!hit && c == 2 * n - 2)  ii[s] = fbyte[7:4];
            else if (!hit && c == 2 * n) ii[s] = fbyte[3:0];
            else                         ii[s] = 4'($urandom);
            if (c < last + 1) @(negedge clk);
        end
        mb_v[s] = 1;
        mb_a[s] = addr;
        mb_d[s] = exp_d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            rv[s] = 1'b0; ra[s] = 12'h000; ii[s] = 4'h0;
        end
        clear_model();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if ({cs[s], sk[s], oe[s], vv[s], rr[s], io[s], rd[s]} !== {5'b10000, 4'h0, 8'h00}) begin
                fails++;
                $display("FAIL reset_state s%0d: got %b_%h_%h required 10000_0_00",
                         s, {cs[s], sk[s], oe[s], vv[s], rr[s]}, io[s], rd[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (rr[s] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release_ready s%0d: got %b required 1", s, rr[s]);
            end
        end
    endtask

    task automatic test_miss_basic();
        run_txn(0, 12'h123, 8'hA5, 0, 12'h000);
    endtask

    task automatic test_hit();
        run_txn(0, 12'h123, 8'h00, 0, 12'h000);
    endtask

    task automatic test_base_wrap();
        run_txn(1, 12'h020, 8'($urandom), 0, 12'h000);
    endtask

    task automatic test_dummy0();
        run_txn(2, 12'($urandom), 8'($urandom), 0, 12'h000);
        run_txn(2, 12'hFFF, 8'($urandom), 0, 12'h000);
    endtask

    task automatic test_random();
        logic [11:0] pool[4];
        for (int i = 0; i < 4; i++) pool[i] = 12'($urandom);
        for (int i = 0; i < 24; i++)
            run_txn($urandom_range(0, 2), pool[$urandom_range(0, 3)], 8'($urandom), 0, 12'h000);
    endtask

    task automatic test_reset_mid();
        run_txn(0, 12'h3C4, 8'h5A, 0, 12'h000);
        rv[0] = 1'b1;
        ra[0] = 12'h7E1;
        @(negedge clk);
        rv[0] = 1'b0;
        for (int c = 1; c < 10; c++) begin
            tests++;
            if (vv[0] !== 1'b0 || cs[0] !== 1'b0) begin
                fails++;
                $display("FAIL abort_busy cyc%0d: rsp_valid=%b cs_n=%b required 0 0", c, vv[0], cs[0]);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cs[0], sk[0], oe[0], vv[0], rr[0]} !== 5'b10000) begin
            fails++;
            $display("FAIL abort_reset: {cs_n,sclk,oe,rsp_valid,ready}=%b required 10000",
                     {cs[0], sk[0], oe[0], vv[0], rr[0]});
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 12'h3C4, 8'($urandom), 0, 12'h000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn(0, (i % 2) ? 12'h002 : 12'h001, 8'($urandom), (i < 5),
                    (i % 2) ? 12'h001 : 12'h002);
        rv[0] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_miss_basic();
        test_hit();
        test_base_wrap();
        test_dummy0();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qspi_rom_fetch_ctrl.md
Name: qspi_rom_fetch_ctrl

Overview:
- Sequences single-byte cartridge ROM reads over the 4-bit QSPI PMOD link: select, clock, command/address nibbles out, data nibbles in.
- Sits between the console's ROM read port and the pmod2 QSPI pins: io_out on [3:0], sclk on [4], cs_n on [5], io_in on [3:0].
- Holds a one-entry last-address buffer, so a repeated fetch of the same address skips the bus.

Parameters:
- ADDR_W, 12, width of the request address in bytes (4 KB cartridge).
- BASE_ADDR, 24'h000000, flash offset added to the request address.
- CMD, 8'hEB, read command byte, sent as 2 nibbles in quad mode.
- DUMMY, 4, dummy nibble slots between address and data (range 0..15).

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request
- req_addr  in  ADDR_W  byte address
- req_ready  out  1  request accepted when req_valid&&req_ready at a rising edge
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  8  fetched byte
- qspi_cs_n  out  1  flash select, active low
- qspi_sclk  out  1  serial clock, idles low (mode 0)
- qspi_io_out  out  4  command/address nibble
- qspi_io_oe  out  1  1 = block drives io lines
- qspi_io_in  in  4  data nibble from flash

Behaviour:
- Reset (async, while rst_n=0), effective immediately including mid-transaction:
  - cs_n=1, sclk=0, io_out=0, io_oe=0, rsp_valid=0, rsp_data=0, req_ready=0.
  - buf_valid=0, state=IDLE.
- First cycle after rst_n rises: IDLE, req_ready=1.
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- Phase bit ph alternates 0/1 in CMD..DATA; sclk = ph, so sclk = clk/2.
- Each nibble slot is 2 cycles: io_out changes only when ph=0; flash samples on the sclk rise.
- req_ready=1 only in IDLE. No requests are queued; req_valid in other states is ignored.
- Buffer hit: accept with buf_valid && req_addr==buf_addr.
  - Next cycle: DONE, rsp_valid=1, rsp_data=buf_data.
  - Bus untouched; latency 1.
- Miss: accept registers addr; next cycle enters CMD, ph=0, cs_n=0.
  - Wire address A = BASE_ADDR + zero-extended addr, mod 2^24.
- CMD: 2 slots, CMD[7:4] then CMD[3:0], io_oe=1.
- ADDR: 6 slots, A[23:20] first down to A[3:0], io_oe=1.
- DUMMY: DUMMY slots, io_oe=0, io_out=0. DUMMY=0 skips the state.
- DATA: 2 slots, io_oe=0.
  - At the edge ending each ph=1 cycle, capture io_in: first nibble -> byte[7:4], second -> byte[3:0].
- N = 10+DUMMY slots, so cs_n=0 for exactly 2N cycles (cycles 1..2N after accept).
- Cycle 2N+1: DONE, cs_n=1, sclk=0, rsp_valid=1, rsp_data=captured byte.
  - Buffer updates: buf_addr=addr, buf_data=byte, buf_valid=1.
- DONE always returns to IDLE next cycle. Minimum cs_n high time between bus transactions is 2 cycles.
- Default miss latency is 29 cycles accept-to-rsp_valid; next accept at cycle 30 at the earliest.
- rsp_data holds its value until the next rsp_valid.
- Nibble counter width ≥5 bits; no wrap inside a transaction.

Test Plan:
- Reset, then req addr 12'h123, io_in model returns 8'hA5 -> io_out sequence E,B,0,0,0,1,2,3 with io_oe=1; 4 dummy slots with io_oe=0; rsp_valid at cycle 29, rsp_data=8'hA5; cs_n low exactly cycles 1..28.
- Repeat 12'h123, flash model now returning 8'h00 -> rsp_valid at cycle 1, data 8'hA5; cs_n and sclk stay idle throughout.
- BASE_ADDR=24'hFFFFF0, addr 12'h020 -> address nibbles 0,0,0,0,1,0 (wraps mod 2^24).
- DUMMY=0 -> rsp_valid at cycle 21; first DATA sclk rise immediately follows the last ADDR slot.
- Assert rst_n=0 at cycle 10 of a miss -> cs_n=1 and sclk=0 at once, with no rsp_valid. After release, a request to the same address is a miss (full 29-cycle transaction).
- Hold req_valid continuously, alternating 12'h001/12'h002 -> accepts only in IDLE, every response is a miss, and each rsp_data matches the flash model.
